count_ctrl_fsm: RTL
===================

// Module: count_ctrl_fsm
// PURPOSE
//  Control sequencer for the 0..99 up/down BCD-range counter on the edge board.
//  Turns held push-buttons (sampled at clk_1Hz) into the counter's start/stop/
//  load/updown controls. Also stops the count at a programmable target and flags done.
//  Sits between the button inputs and the counter; count is fed back for target compare.
// PARAMETERS
//  CNT_W        7   width of count/target buses
//  CNT_MAX      99  highest legal count; target > CNT_MAX disables the compare
//  AUTO_REVERSE 0   1: on target hit, toggle direction and resume after one DONE cycle
// PORTS
//  clk_1Hz    in   1      counter tick clock
//  reset      in   1      asynchronous, active-high
//  btn_run    in   1      run/resume button, level; rising edge acts
//  btn_pause  in   1      pause button, level; rising edge acts
//  btn_dir    in   1      direction toggle button, level; rising edge acts
//  btn_load   in   1      preset load button, level; rising edge acts
//  target_en  in   1      enable target compare
//  target     in   CNT_W  stop value
//  count      in   CNT_W  current counter value (feedback)
//  start      out  1      to counter: count enable
//  stop       out  1      to counter: hold
//  updown     out  1      to counter: 0 up, 1 down
//  load       out  1      to counter: preset (90 up / 10 down)
//  done       out  1      target reached, held until next run edge
//  state      out  3      FSM state code for debug LEDs
// BEHAVIOUR
//  - Edge detect: btn_*_q registered (reset 0); edge = btn & ~btn_q. One action per press.
//  - Edge priority in one cycle: load > pause > run. Dir edge is evaluated independently.
//  - dir_r register (reset 0) drives updown.
//    Dir edge toggles dir_r only in IDLE, PAUSE and DONE; it is ignored in RUN and LOAD.
//  - States/codes: IDLE=0 RUN=1 PAUSE=2 LOAD=3 DONE=4. Reset -> IDLE.
//  - All outputs are decoded from the state register:
//      IDLE : start0 stop1 load0 done0
//      RUN  : start1 stop0 load0 done0
//      PAUSE: start1 stop1 load0 done0
//      LOAD : start1 stop0 load1 done0
//      DONE : start0 stop1 load0 done1
//  - Reset values: start0 stop1 updown0 load0 done0 state0.
//  - Transitions:
//      IDLE : load_edge->LOAD; run_edge->RUN
//      RUN  : load_edge->LOAD; pause_edge->PAUSE; match->DONE
//      PAUSE: load_edge->LOAD; run_edge->RUN
//      LOAD : unconditional ->PAUSE after exactly 1 cycle (counter takes the preset)
//      DONE : AUTO_REVERSE=1: toggle dir_r, ->RUN next cycle
//             AUTO_REVERSE=0: run_edge->RUN; load_edge->LOAD; otherwise stay
//  - match = (state==RUN) & target_en & (target<=CNT_MAX) & (count==target) & ~first_run.
//    It is combinational on count.
//  - While in RUN, stop is also forced to 1 combinationally when match is true.
//    The counter therefore halts exactly on target, with no overshoot.
//  - first_run is set on every entry to RUN and cleared after the first RUN cycle.
//    This lets a restart from DONE leave the target value.
//  - Rollover (99<->0) belongs to the counter; the FSM does not react to it.
//  - Asynchronous reset mid-operation forces IDLE at once; pending button edges are discarded.
// TESTING
//  1. Reset, press run; counter up from 0 -> start=1 stop=0 and count 0,1,2..; state=1.
//  2. target_en=1, target=5, run -> count stops at 5 and holds; done=1, state=4.
//     Then run edge -> count 6, done=0.
//  3. In PAUSE press dir, then run -> updown=1 and count decrements.
//     A dir press while in RUN leaves updown unchanged.
//  4. In RUN press load with updown=0 -> exactly one cycle of load=1 start=1 stop=0.
//     Count becomes 90; next cycle state=PAUSE and count holds at 90.
//  5. AUTO_REVERSE=1, target=3, up from 0 -> stops at 3, one DONE cycle, then updown=1.
//     Count runs 2,1,0,99.
//  6. Same cycle: load and pause edges -> LOAD wins. Assert reset while in RUN -> IDLE.
//     start=0 stop=1 immediately.

Source files
------------

// File: rtl/count_ctrl_fsm_if.sv
// rtl/count_ctrl_fsm_if.sv - button/counter control bundle for count_ctrl_fsm
//
// Purpose: groups the button inputs, target compare inputs, counter feedback
//          and counter control outputs of count_ctrl_fsm into one bundle.
// Signals:
//   btn_run, btn_pause, btn_dir, btn_load  level buttons sampled at clk_1Hz
//   target_en, target[CNT_W]               target compare enable and value
//   count[CNT_W]                           counter value fed back
//   start, stop, updown, load              counter controls
//   done                                   target reached flag
//   state[3]                               FSM state code for debug LEDs
// Modports:
//   master : button/counter side (drives buttons, target, count)
//   slave  : the sequencer (drives counter controls, done, state)

interface count_ctrl_fsm_if #(
   parameter int CNT_W = 7
);
   logic             btn_run;
   logic             btn_pause;
   logic             btn_dir;
   logic             btn_load;
   logic             target_en;
   logic [CNT_W-1:0] target;
   logic [CNT_W-1:0] count;
   logic             start;
   logic             stop;
   logic             updown;
   logic             load;
   logic             done;
   logic [2:0]       state;

   modport master (
      output btn_run, btn_pause, btn_dir, btn_load,
      output target_en, target, count,
      input  start, stop, updown, load, done, state
   );

   modport slave (
      input  btn_run, btn_pause, btn_dir, btn_load,
      input  target_en, target, count,
      output start, stop, updown, load, done, state
   );
endinterface

// File: rtl/count_ctrl_fsm.sv
// rtl/count_ctrl_fsm.sv - button-driven control sequencer for the 0..99 counter
//
// Purpose: turns held push-buttons (one action per press) into start/stop/
//          load/updown controls for an up/down counter, halts the counter
//          exactly on a programmable target and flags done.
// Parameters:
//   CNT_W        width of count/target
//   CNT_MAX      highest legal count; a target above it disables the compare
//   AUTO_REVERSE 1: on target hit, flip direction and resume after one DONE cycle
// Ports:
//   clk_1Hz  counter tick clock
//   reset    asynchronous, active-high
//   bus      count_ctrl_fsm_if slave: buttons, target, count in;
//            start/stop/updown/load/done/state out

module count_ctrl_fsm #(
   parameter int CNT_W        = 7,
   parameter int CNT_MAX      = 99,
   parameter bit AUTO_REVERSE = 1'b0
) (
   input  logic                 clk_1Hz,
   input  logic                 reset,
   count_ctrl_fsm_if.slave      bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_PAUSE = 3'd2,
      ST_LOAD  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX_V = CNT_W'(CNT_MAX);

   state_t state_q, state_d;

   logic btn_run_q, btn_pause_q, btn_dir_q, btn_load_q;
   logic dir_q, dir_d;
   logic first_run_q, first_run_d;
   logic start_q, start_d;
   logic stop_q, stop_d;
   logic load_q, load_d;
   logic done_q, done_d;

   logic run_edge, pause_edge, dir_edge, load_edge;
   logic match;

   assign run_edge   = bus.btn_run   & ~btn_run_q;
   assign pause_edge = bus.btn_pause & ~btn_pause_q;
   assign dir_edge   = bus.btn_dir   & ~btn_dir_q;
   assign load_edge  = bus.btn_load  & ~btn_load_q;

   // Compare is combinational on count so stop can assert in the same cycle
   // the counter lands on target. first_run_q masks it for one cycle so a
   // restart from DONE can step off the target value.
   assign match = (state_q == ST_RUN) & bus.target_en & (bus.target <= CNT_MAX_V)
                & (bus.count == bus.target) & ~first_run_q;

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;

      case (state_q)
         ST_IDLE: begin
            if (load_edge)     state_d = ST_LOAD;
            else if (run_edge) state_d = ST_RUN;
            if (dir_edge)      dir_d   = ~dir_q;
         end
         ST_RUN: begin
            if (load_edge)       state_d = ST_LOAD;
            else if (pause_edge) state_d = ST_PAUSE;
            else if (match)      state_d = ST_DONE;
         end
         ST_PAUSE: begin
            if (load_edge)     state_d = ST_LOAD;
            else if (run_edge) state_d = ST_RUN;
            if (dir_edge)      dir_d   = ~dir_q;
         end
         ST_LOAD: begin
            // The counter takes the preset during this single cycle.
            state_d = ST_PAUSE;
         end
         ST_DONE: begin
            if (AUTO_REVERSE) begin
               state_d = ST_RUN;
               // A dir press coinciding with the auto flip cancels it.
               dir_d   = ~(dir_q ^ dir_edge);
            end else begin
               if (load_edge)     state_d = ST_LOAD;
               else if (run_edge) state_d = ST_RUN;
               if (dir_edge)      dir_d   = ~dir_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign first_run_d = (state_d == ST_RUN) && (state_q != ST_RUN);

   // Outputs are decoded from the next state and registered with it, so the
   // registered copies always reflect the current state register.
   always_comb begin
      start_d = 1'b0;
      stop_d  = 1'b1;
      load_d  = 1'b0;
      done_d  = 1'b0;
      case (state_d)
         ST_IDLE:  begin start_d = 1'b0; stop_d = 1'b1; load_d = 1'b0; done_d = 1'b0; end
         ST_RUN:   begin start_d = 1'b1; stop_d = 1'b0; load_d = 1'b0; done_d = 1'b0; end
         ST_PAUSE: begin start_d = 1'b1; stop_d = 1'b1; load_d = 1'b0; done_d = 1'b0; end
         ST_LOAD:  begin start_d = 1'b1; stop_d = 1'b0; load_d = 1'b1; done_d = 1'b0; end
         ST_DONE:  begin start_d = 1'b0; stop_d = 1'b1; load_d = 1'b0; done_d = 1'b1; end
         default:  begin start_d = 1'b0; stop_d = 1'b1; load_d = 1'b0; done_d = 1'b0; end
      endcase
   end

   always_ff @(posedge clk_1Hz or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         btn_run_q   <= 1'b0;
         btn_pause_q <= 1'b0;
         btn_dir_q   <= 1'b0;
         btn_load_q  <= 1'b0;
         dir_q       <= 1'b0;
         first_run_q <= 1'b0;
         start_q     <= 1'b0;
         stop_q      <= 1'b1;
         load_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         btn_run_q   <= bus.btn_run;
         btn_pause_q <= bus.btn_pause;
         btn_dir_q   <= bus.btn_dir;
         btn_load_q  <= bus.btn_load;
         dir_q       <= dir_d;
         first_run_q <= first_run_d;
         start_q     <= start_d;
         stop_q      <= stop_d;
         load_q      <= load_d;
         done_q      <= done_d;
      end
   end

   assign bus.start  = start_q;
   // Halts the counter on the very cycle it reaches target.
   assign bus.stop   = stop_q | match;
   assign bus.load   = load_q;
   assign bus.done   = done_q;
   assign bus.updown = dir_q;
   assign bus.state  = state_q;

endmodule
